// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca4_slice.sv
// 4-bit ripple-carry slice built from four chained 1-bit full adders.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it has no handshake of its own.
module rca4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock, carry registered between nibbles.
// Latency: out_valid rises WIDTH/4 cycles after the accept edge; one op per WIDTH/4+2 cycles at best.
// Backpressure: result and out_valid hold in DONE until out_ready; in_ready stays low until then.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [NIB_W-1:0] slice_a;
    logic [NIB_W-1:0] slice_b;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] sum_upd;

    // Constant-index loops keep nibble select/merge free of variable part-selects.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        sum_upd = sum_q;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == IDX_W'(n)) begin
                slice_a                    = a_q[n*NIB_W +: NIB_W];
                slice_b                    = b_q[n*NIB_W +: NIB_W];
                sum_upd[n*NIB_W +: NIB_W]  = slice_sum;
            end
        end
    end

    rca4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (idx_q == IDX_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_upd;
                    carry_q <= slice_cout;
                    // idx parks on the last nibble so it never exceeds NIB-1.
                    if (idx_q == IDX_LAST) begin
                        cout_q <= slice_cout;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed 16-bit scenarios plus randomized 4- and 32-bit streams.
module tb_nibble_serial_adder;

    localparam int N_RAND = 1000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    logic        d_in_valid, d_in_ready, d_in_cin, d_out_valid, d_out_ready, d_out_cout, d_busy;
    logic [15:0] d_in_a, d_in_b, d_out_sum;

    logic [1:0]  r_in_valid, r_out_ready;
    logic [31:0] r_a, r_b;
    logic        r_cin;
    logic        rdy4, ov4, c4, busy4, rdy32, ov32, c32, busy32;
    logic [3:0]  s4;
    logic [31:0] s32;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_a(d_in_a), .in_b(d_in_b), .in_cin(d_in_cin), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_sum(d_out_sum), .out_cout(d_out_cout), .busy(d_busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[0]), .in_ready(rdy4),
        .in_a(r_a[3:0]), .in_b(r_b[3:0]), .in_cin(r_cin), .out_valid(ov4),
        .out_ready(r_out_ready[0]), .out_sum(s4), .out_cout(c4), .busy(busy4)
    );

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[1]), .in_ready(rdy32),
        .in_a(r_a), .in_b(r_b), .in_cin(r_cin), .out_valid(ov32),
        .out_ready(r_out_ready[1]), .out_sum(s32), .out_cout(c32), .busy(busy32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        #2;
        n_checks++; if (d_in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", d_in_ready); else n_pass++;
        n_checks++; if (d_out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", d_out_valid); else n_pass++;
        n_checks++; if (d_out_sum !== 16'h0) $display("FAIL reset out_sum: got %h want 0000", d_out_sum); else n_pass++;
        n_checks++; if (d_out_cout !== 1'b0) $display("FAIL reset out_cout: got %b want 0", d_out_cout); else n_pass++;
        n_checks++; if (d_busy !== 1'b0) $display("FAIL reset busy: got %b want 0", d_busy); else n_pass++;
        n_checks++;
        if ({ov4, ov32, rdy4, rdy32} !== 4'b0011)
            $display("FAIL reset small/wide duts: got %b want 0011", {ov4, ov32, rdy4, rdy32});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Offer one op to the 16-bit DUT and leave it stalled in DONE (out_ready low).
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic [16:0] exp, input string name);
        int first;
        d_in_a = a; d_in_b = b; d_in_cin = cin; d_in_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (d_in_ready !== 1'b1) $display("FAIL %s in_ready at offer: got %b want 1", name, d_in_ready); else n_pass++;
        @(posedge clk); #1;
        d_in_valid = 1'b0; d_in_a = ~a; d_in_b = ~b; d_in_cin = ~cin;
        first = -1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_out_valid === 1'b1 && first < 0) first = k;
        end
        n_checks++; if (first !== 4) $display("FAIL %s latency: got %0d cycles want 4", name, first); else n_pass++;
        n_checks++; if (d_out_sum !== exp[15:0]) $display("FAIL %s out_sum: got %h want %h", name, d_out_sum, exp[15:0]); else n_pass++;
        n_checks++; if (d_out_cout !== exp[16]) $display("FAIL %s out_cout: got %b want %b", name, d_out_cout, exp[16]); else n_pass++;
        n_checks++; if (d_busy !== 1'b1) $display("FAIL %s busy in DONE: got %b want 1", name, d_busy); else n_pass++;
    endtask

    task automatic finish_op(input string name);
        @(posedge clk); #1;
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        d_out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({d_out_valid, d_in_ready} !== 2'b01)
            $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0 1", name, d_out_valid, d_in_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        start_op(16'h1234, 16'h1111, 1'b0, 17'h0_2345, "add_1234_1111"); finish_op("add_1234_1111");
        start_op(16'hFFFF, 16'h0000, 1'b1, 17'h1_0000, "ripple_ffff_cin"); finish_op("ripple_ffff_cin");
        start_op(16'h8000, 16'h8000, 1'b0, 17'h1_0000, "top_carry_8000"); finish_op("top_carry_8000");
        start_op(16'h0F0F, 16'h00F1, 1'b0, 17'h0_1000, "mid_carry_0f0f"); finish_op("mid_carry_0f0f");
    endtask

    task automatic test_backpressure();
        start_op(16'hF00D, 16'h2FF3, 1'b0, 17'h1_2000, "stall_op");
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            d_in_valid = (k == 2); d_in_a = 16'h0001; d_in_b = 16'h0001; d_in_cin = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({d_out_valid, d_in_ready, d_out_cout, d_out_sum} !== {1'b1, 1'b0, 1'b1, 16'h2000})
                $display("FAIL stall cycle %0d: got ov=%b ir=%b cout=%b sum=%h want 1 0 1 2000",
                         k, d_out_valid, d_in_ready, d_out_cout, d_out_sum);
            else n_pass++;
        end
        d_in_valid = 1'b0;
        finish_op("stall_op");
        @(negedge clk);
        n_checks++; if (d_busy !== 1'b0) $display("FAIL stall pulse captured: busy got %b want 0", d_busy); else n_pass++;
        n_checks++; if (d_out_sum !== 16'h2000) $display("FAIL stall idle sum: got %h want 2000", d_out_sum); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        d_in_a = 16'h1234; d_in_b = 16'h4321; d_in_cin = 1'b0; d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (d_out_valid !== 1'b0) $display("FAIL midrst out_valid: got %b want 0", d_out_valid); else n_pass++;
        n_checks++; if (d_out_sum !== 16'h0) $display("FAIL midrst out_sum: got %h want 0000", d_out_sum); else n_pass++;
        n_checks++; if (d_in_ready !== 1'b1) $display("FAIL midrst in_ready: got %b want 1", d_in_ready); else n_pass++;
        n_checks++; if (d_busy !== 1'b0) $display("FAIL midrst busy: got %b want 0", d_busy); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(16'h0002, 16'h0003, 1'b0, 17'h0_0005, "post_reset");
        finish_op("post_reset");
    endtask

    // Random producer/consumer stream against a queue of a+b+cin sums. sel 0 -> 4-bit, 1 -> 32-bit.
    task automatic test_random(input int sel, input int w);
        logic [32:0] exp_q[$];
        logic [32:0] mask;
        logic [32:0] got_v;
        logic [32:0] exp_v;
        int          got;
        int          cyc;
        bit          abort;
        mask  = (w == 32) ? 33'h0_FFFF_FFFF : ((33'd1 << w) - 33'd1);
        got   = 0;
        abort = 1'b0;
        fork
            begin : producer
                for (int i = 0; i < N_RAND && !abort; i++) begin
                    logic [31:0] a;
                    logic [31:0] b;
                    logic        c;
                    int          guard;
                    bit          acc;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
                    r_a = a; r_b = b; r_cin = c; r_in_valid[sel] = 1'b1;
                    guard = 0; acc = 1'b0;
                    while (!acc && guard < 200) begin
                        @(negedge clk);
                        acc = (sel == 0) ? rdy4 : rdy32;
                        @(posedge clk); #1;
                        guard++;
                    end
                    r_in_valid[sel] = 1'b0;
                    if (acc) begin
                        exp_q.push_back(({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, c});
                        r_a = $urandom; r_b = $urandom; r_cin = ~c;
                    end else begin
                        n_checks++;
                        $display("FAIL rand w%0d accept timeout: op %0d never accepted within 200 cycles", w, i);
                        abort = 1'b1;
                    end
                end
            end
            begin : consumer
                cyc = 0;
                while (got < N_RAND && cyc < N_RAND * 30 && !abort) begin
                    r_out_ready[sel] = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (((sel == 0) ? ov4 : ov32) && r_out_ready[sel]) begin
                        got_v = (sel == 0) ? {28'd0, c4, s4} : {c32, s32};
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL rand w%0d extra result: got %h want none", w, got_v);
                        end else begin
                            exp_v = exp_q.pop_front();
                            if (got_v !== exp_v) $display("FAIL rand w%0d result %0d: got %h want %h", w, got, got_v, exp_v);
                            else n_pass++;
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                r_out_ready[sel] = 1'b0;
            end
        join
        n_checks++;
        if (got !== N_RAND || exp_q.size() != 0)
            $display("FAIL rand w%0d count: got %0d results (%0d pending) want %0d", w, got, exp_q.size(), N_RAND);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0;
        d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0; d_in_cin = 1'b0; d_out_ready = 1'b0;
        r_in_valid = '0; r_out_ready = '0; r_a = '0; r_b = '0; r_cin = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_random(0, 4);
        test_random(1, 32);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
